// File: rtl/riscv_pkg.sv
// Shared RV32I load/store encodings, LSU state enum and latched request payload.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic            op_ld;
    logic [2:0]      func3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] st_data;
  } lsu_req_t;

  // Access size lives in func3[1:0] for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a_lo);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return a_lo[0];
      default: return a_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: store byte enables and replication, load extraction and extension.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]      func3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] st_data_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [BE_W-1:0] be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = st_data_i;
    case (func3_i[1:0])
      F3_SB[1:0]: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      F3_SH[1:0]: begin
        be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{st_data_i[15:0]}};
      end
      F3_SW[1:0]: begin
        be_o    = 4'b1111;
        wdata_o = st_data_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    load_data_o = rdata_i;
    case (func3_i)
      F3_LB:   load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  load_data_o = {24'h0, byte_sel};
      F3_LHU:  load_data_o = {16'h0, half_sel};
      F3_LW:   load_data_o = rdata_i;
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// LSU memory stage: IDLE/REQ/WAIT request-grant-rvalid handshake to data memory.
// Build option LSU_MISALIGN_TRAP_EN adds the misalign port and completes misaligned accesses without a request.
module lsu_mem_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_ld,
  input  logic            in_st,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] st_data,
  output logic            dm_req,
  output logic            dm_we,
  output logic [XLEN-1:0] dm_addr,
  output logic [BE_W-1:0] dm_be,
  output logic [XLEN-1:0] dm_wdata,
  input  logic            dm_gnt,
  input  logic            dm_rvalid,
  input  logic [XLEN-1:0] dm_rdata,
  output logic            stall,
  output logic            out_valid,
  output logic [XLEN-1:0] load_data
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic            misalign
`endif
);

  lsu_state_e      state_q, state_d;
  lsu_req_t        req_q, req_d;
  logic [BE_W-1:0] be;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] ext_data;
  logic            mis_c;

  lsu_align u_align (
    .func3_i     (req_q.func3),
    .addr_lo_i   (req_q.addr[1:0]),
    .st_data_i   (req_q.st_data),
    .rdata_i     (dm_rdata),
    .be_o        (be),
    .wdata_o     (wdata),
    .load_data_o (ext_data)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_c    = is_misaligned(func3, addr[1:0]);
  assign misalign = rst && (state_q == IDLE) && in_valid && (in_ld || in_st) && mis_c;
`else
  assign mis_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  // Handshake outputs are gated by rst so every port reads zero during reset.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_be     = '0;
    dm_wdata  = '0;
    stall     = 1'b0;
    out_valid = 1'b0;
    load_data = '0;
    if (rst) begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (!(in_ld || in_st) || mis_c) begin
              out_valid = 1'b1;
            end else begin
              stall         = 1'b1;
              req_d.op_ld   = in_ld;
              req_d.func3   = func3;
              req_d.addr    = addr;
              req_d.st_data = st_data;
              state_d       = REQ;
            end
          end
        end
        REQ: begin
          dm_req   = 1'b1;
          dm_we    = !req_q.op_ld;
          dm_addr  = {req_q.addr[XLEN-1:2], 2'b00};
          dm_be    = be;
          dm_wdata = req_q.op_ld ? '0 : wdata;
          if (!dm_gnt) begin
            stall = 1'b1;
          end else if (req_q.op_ld) begin
            stall   = 1'b1;
            state_d = WAIT;
          end else begin
            out_valid = 1'b1;
            state_d   = IDLE;
          end
        end
        WAIT: begin
          if (dm_rvalid) begin
            out_valid = 1'b1;
            load_data = ext_data;
            state_d   = IDLE;
          end else begin
            stall = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: directed accesses against a delay-programmable memory model.
module tb_lsu_mem_stage;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_req_t;

  typedef struct {
    logic [31:0] ld;
    logic        mis;
  } exp_cpl_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_ld = 1'b0, in_st = 1'b0;
  logic [2:0]  func3 = 3'b000;
  logic [31:0] addr = '0, st_data = '0;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_gnt = 1'b0, dm_rvalid = 1'b0;
  logic [31:0] dm_rdata = '0;
  logic        stall, out_valid;
  logic [31:0] load_data;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int n_vec = 0;
  int n_err = 0;

  exp_req_t exp_req_q[$];
  exp_cpl_t exp_cpl_q[$];

  int          gnt_delay = 0, rv_delay = 0, gnt_cnt = 0, rv_cnt = 0;
  logic        pend_rv = 1'b0, stray = 1'b0;
  logic [31:0] rdata_v = '0;

  lsu_mem_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ld     (in_ld),
    .in_st     (in_st),
    .func3     (func3),
    .addr      (addr),
    .st_data   (st_data),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_be     (dm_be),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .stall     (stall),
    .out_valid (out_valid),
    .load_data (load_data)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .misalign  (misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: grants after gnt_delay REQ cycles, returns rdata rv_delay cycles after grant.
  always @(posedge clk) begin
    #1;
    dm_gnt    = 1'b0;
    dm_rvalid = 1'b0;
    dm_rdata  = 32'h5A5A_0000;
    if (stray) begin
      dm_gnt    = 1'b1;
      dm_rvalid = 1'b1;
      dm_rdata  = 32'hFFFF_FFFF;
    end else if (dm_req) begin
      if (exp_req_q.size() == 0) begin
        check("dm_req_expected", 32'(dm_req), 32'h0);
      end else begin
        check("dm_we", 32'(dm_we), 32'(exp_req_q[0].we));
        check("dm_addr", dm_addr, exp_req_q[0].addr);
        check("dm_be", 32'(dm_be), 32'(exp_req_q[0].be));
        if (exp_req_q[0].we) check("dm_wdata", dm_wdata, exp_req_q[0].wdata);
        if (gnt_cnt == gnt_delay) begin
          dm_gnt  = 1'b1;
          gnt_cnt = 0;
          if (!exp_req_q[0].we) begin
            pend_rv = 1'b1;
            rv_cnt  = 0;
          end
          void'(exp_req_q.pop_front());
        end else begin
          gnt_cnt++;
        end
      end
    end else if (pend_rv) begin
      if (rv_cnt == rv_delay) begin
        dm_rvalid = 1'b1;
        dm_rdata  = rdata_v;
        pend_rv   = 1'b0;
      end else begin
        rv_cnt++;
      end
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    exp_cpl_t c;
    if (out_valid) begin
      if (exp_cpl_q.size() == 0) begin
        check("out_valid_expected", 32'(out_valid), 32'h0);
      end else begin
        c = exp_cpl_q.pop_front();
        check("load_data", load_data, c.ld);
`ifdef LSU_MISALIGN_TRAP_EN
        check("misalign", 32'(misalign), 32'(c.mis));
`endif
      end
    end else begin
      check("load_data_idle_zero", load_data, 32'h0);
    end
  end

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       input int gd, input int rd, input logic [31:0] rdat,
                       input int exp_lat, input logic req_v, input logic [3:0] ebe,
                       input logic [31:0] ewd, input logic [31:0] eld, input logic emis);
    exp_req_t r;
    exp_cpl_t c;
    int       lat;
    logic     done;
    gnt_delay = gd;
    rv_delay  = rd;
    rdata_v   = rdat;
    if (req_v) begin
      r.we    = st & !ld;
      r.addr  = {a[31:2], 2'b00};
      r.be    = ebe;
      r.wdata = ewd;
      exp_req_q.push_back(r);
    end
    c.ld  = eld;
    c.mis = emis;
    exp_cpl_q.push_back(c);
    in_valid = 1'b1; in_ld = ld; in_st = st; func3 = f3; addr = a; st_data = d;
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 64) begin
      @(negedge clk);
      lat++;
      if (!stall) done = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_ld = 1'b0; in_st = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b1; in_ld = 1'b1; func3 = LW; addr = 32'h104; st_data = 32'h55;
    #3;
    check("reset_ctrl", 32'({dm_req, dm_we, stall, out_valid, dm_be}), 32'h0);
    check("reset_data", dm_addr | dm_wdata | load_data, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("reset_misalign", 32'(misalign), 32'h0);
`endif
    in_valid = 1'b0; in_ld = 1'b0;
    #9 rst = 1'b1;
    @(posedge clk); #1;

    //    ld st f3   addr          data          gd rd rdata         lat rq be     wdata         load          mis
    issue(0, 1, SW,  32'h100, 32'hDEADBEEF, 0, 0, 32'h0,        2, 1, 4'hF, 32'hDEADBEEF, 32'h0,        0);
    issue(1, 0, LB,  32'h103, 32'h0,        0, 0, 32'h80112233, 3, 1, 4'h8, 32'h0,        32'hFFFFFF80, 0);
    issue(1, 0, LBU, 32'h103, 32'h0,        0, 0, 32'h80112233, 3, 1, 4'h8, 32'h0,        32'h00000080, 0);
    issue(1, 0, LH,  32'h102, 32'h0,        3, 1, 32'h80112233, 7, 1, 4'hC, 32'h0,        32'hFFFF8011, 0);
    issue(0, 1, SB,  32'h101, 32'h000000AB, 0, 0, 32'h0,        2, 1, 4'h2, 32'hABABABAB, 32'h0,        0);
    issue(0, 1, SH,  32'h202, 32'h1234CAFE, 1, 0, 32'h0,        3, 1, 4'hC, 32'hCAFECAFE, 32'h0,        0);
    issue(1, 0, LHU, 32'h200, 32'h0,        0, 2, 32'h7654F00D, 5, 1, 4'h3, 32'h0,        32'h0000F00D, 0);
    issue(1, 0, LH,  32'h200, 32'h0,        0, 0, 32'h7654F00D, 3, 1, 4'h3, 32'h0,        32'hFFFFF00D, 0);
    issue(1, 0, LW,  32'h204, 32'h0,        0, 0, 32'h13579BDF, 3, 1, 4'hF, 32'h0,        32'h13579BDF, 0);
    issue(0, 0, LW,  32'h300, 32'h0,        0, 0, 32'h0,        1, 0, 4'h0, 32'h0,        32'h0,        0);
    issue(1, 1, LW,  32'h300, 32'h99,       0, 0, 32'hA5A5A5A5, 3, 1, 4'hF, 32'h0,        32'hA5A5A5A5, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1, 0, LW,  32'h102, 32'h0,        0, 0, 32'h11223344, 1, 0, 4'h0, 32'h0,        32'h0,        1);
    issue(0, 1, SH,  32'h103, 32'h5566,     0, 0, 32'h0,        1, 0, 4'h0, 32'h0,        32'h0,        1);
    issue(1, 0, LH,  32'h101, 32'h0,        0, 0, 32'hAABBCCDD, 1, 0, 4'h0, 32'h0,        32'h0,        1);
`else
    issue(1, 0, LW,  32'h102, 32'h0,        0, 0, 32'h11223344, 3, 1, 4'hF, 32'h0,        32'h11223344, 0);
    issue(0, 1, SH,  32'h103, 32'h5566,     0, 0, 32'h0,        2, 1, 4'hC, 32'h55665566, 32'h0,        0);
    issue(1, 0, LH,  32'h101, 32'h0,        0, 0, 32'hAABBCCDD, 3, 1, 4'h3, 32'h0,        32'hFFFFCCDD, 0);
`endif

    // Stray grant/rvalid while idle must be ignored.
    stray = 1'b1;
    repeat (3) begin
      @(posedge clk); #2;
      check("stray_no_req", 32'(dm_req), 32'h0);
      check("stray_no_stall", 32'(stall), 32'h0);
    end
    stray = 1'b0;
    @(posedge clk); #1;

    // Reset while waiting for read data; the late rvalid must not complete anything.
    gnt_delay = 0; rv_delay = 4; rdata_v = 32'h80112233;
    exp_req_q.push_back('{we: 1'b0, addr: 32'h100, be: 4'hC, wdata: 32'h0});
    in_valid = 1'b1; in_ld = 1'b1; in_st = 1'b0; func3 = LH; addr = 32'h102;
    @(posedge clk); #1;
    @(posedge clk); #2;
    check("wait_stall", 32'(stall), 32'h1);
    rst = 1'b0; in_valid = 1'b0; in_ld = 1'b0;
    #1;
    check("midreset_ctrl", 32'({dm_req, dm_we, stall, out_valid, dm_be}), 32'h0);
    check("midreset_data", dm_addr | dm_wdata | load_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    check("post_reset_stall", 32'(stall), 32'h0);
    check("post_reset_req", 32'(dm_req), 32'h0);
    @(posedge clk); #1;

    issue(0, 1, SW,  32'h10C, 32'h0BADF00D, 0, 0, 32'h0,        2, 1, 4'hF, 32'h0BADF00D, 32'h0,        0);
    repeat (3) @(posedge clk);
    #1;
    check("cpl_queue_drained", 32'(exp_cpl_q.size()), 32'h0);
    check("req_queue_drained", 32'(exp_req_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-low.
REQ-003 in_valid  in  1  instruction present in memory stage.
REQ-004 in_ld  in  1  instruction is a load.
REQ-005 in_st  in  1  instruction is a store.
REQ-006 func3  in  3  RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-007 addr  in  32  effective address from ALU.
REQ-008 st_data  in  32  store source register value.
REQ-009 dm_req  out  1  data-memory request.
REQ-010 dm_we  out  1  request is a write.
REQ-011 dm_addr  out  32  word address, bits [1:0] forced 0.
REQ-012 dm_be  out  4  byte enables.
REQ-013 dm_wdata  out  32  lane-replicated write data.
REQ-014 dm_gnt  in  1  memory accepted request this cycle.
REQ-015 dm_rvalid  in  1  read data valid this cycle.
REQ-016 dm_rdata  in  32  read word.
REQ-017 stall  out  1  freeze upstream stages and hold inputs stable.
REQ-018 out_valid  out  1  access complete; downstream register captures this cycle.
REQ-019 load_data  out  32  aligned, extended load result.
REQ-020 misalign  out  1  misaligned-access flag (present only with MISALIGN_TRAP_EN).

Function
REQ-021 FSM states SHALL be IDLE, REQ, WAIT.
REQ-022 IDLE: accept = in_valid & (in_ld|in_st); on accept latch addr/func3/st_data/op, go REQ.
REQ-023 in_ld and in_st both high SHALL be treated as load.
REQ-024 in_valid without ld/st SHALL complete same cycle: out_valid=1, stall=0, no dm_req.
REQ-025 REQ: dm_req=1 held with stable dm_we/addr/be/wdata until dm_gnt; store+gnt -> IDLE with out_valid=1; load+gnt -> WAIT.
REQ-026 WAIT: on dm_rvalid, out_valid=1, load_data valid combinationally, -> IDLE.
REQ-027 stall = accept | (state==REQ & !dm_gnt) | (state==REQ & dm_gnt & load) | (state==WAIT & !dm_rvalid).
REQ-028 Minimum latency: store 2 cycles (accept, grant), load 3 cycles (accept, grant, rvalid).
REQ-029 dm_be: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111.
REQ-030 dm_wdata: SB byte x4, SH halfword x2, SW word.
REQ-031 Load select by addr[1:0]/addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-032 dm_rvalid outside WAIT and dm_gnt outside REQ SHALL be ignored.
REQ-033 load_data SHALL be 0 whenever out_valid=0 or op is not a load.

Reset
REQ-034 rst low SHALL immediately force IDLE, dm_req=0, dm_we=0, dm_be=0, dm_addr=0, dm_wdata=0, out_valid=0, stall=0, load_data=0, misalign=0, latched fields 0.
REQ-035 Reset mid-access SHALL abandon the transaction; late dm_gnt/dm_rvalid after reset release SHALL be ignored.

Configuration
REQ-036 Macro LSU_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL issue no dm_req, complete in accept cycle with out_valid=1, misalign=1, stall=0.
REQ-037 Macro undefined: misalign port absent; misaligned accesses issued using REQ-029/031 lane rules (low address bits above the size truncated).

Structure
REQ-038 Shared package riscv_pkg SHALL hold func3 load/store constants and the FSM state enum.
REQ-039 Sub-module lsu_align (combinational: byte-enable, write replication, load extract/extend) SHALL be instantiated once.

Verification
REQ-040 SW addr=0x100 data=0xDEADBEEF, gnt immediate -> dm_be=1111, dm_wdata=0xDEADBEEF, out_valid in cycle 2.
REQ-041 LB addr=0x103, rdata=0x80112233 -> load_data=0xFFFFFF80; LBU -> 0x00000080.
REQ-042 LH addr=0x102, gnt delayed 3 cycles, rvalid 2 cycles later -> stall high throughout, load_data=0xFFFF8011, out_valid exactly one cycle.
REQ-043 SB addr=0x101 data=0x000000AB -> dm_be=0010, dm_wdata=0xABABABAB.
REQ-044 rst low while in WAIT, then rvalid after release -> IDLE, out_valid never asserts.
REQ-045 With LSU_MISALIGN_TRAP_EN, LW addr=0x102 -> dm_req stays 0, misalign=1 and out_valid=1 same cycle.
